serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/serial_addsub_full_adder.sv | 20 ++
 rtl/serial_addsub.sv | 100 ++++++++++
 tb/tb_serial_addsub.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: default width and FSM encoding.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Gate-level one-bit full adder; the only arithmetic cell in the serial datapath.
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (cx_a, ab_x, cin);
  or  g_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full adder processes the operands LSB first,
// one bit per cycle, producing result, carry and signed overflow after WIDTH cycles.
//
// Handshake: start is a request sampled only while idle (busy=0); there is no
// ready back-pressure, so start in RUN/DONE is dropped. done is a one-cycle valid
// strobe and the result fields hold until the next accepted start.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  structuralFullAdder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters through the carry flop.
            a_sr     <= a;
            b_sr     <= sub ? ~b : b;
            carry    <= sub;
            cnt      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fa_sum, result[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // carry still holds the carry into the MSB here.
            carryout <= fa_cout;
            overflow <= carry ^ fa_cout;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub against an integer-arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_pulses = 0;

  logic [W+1:0] exp_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) done_pulses <= done_pulses + 1;

  // ---------------- reference model ----------------
  // Returns {overflow, carryout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    int ua, ub, sa, sb, uv, sv;
    logic co, ov;
    logic [W-1:0] res;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      uv = ua - ub;
      sv = sa - sb;
      co = (ua >= ub);
    end else begin
      uv = ua + ub;
      sv = sa + sb;
      co = (uv >= (1 << W));
    end
    res = W'(uv & ((1 << W) - 1));
    ov  = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    return {ov, co, res};
  endfunction

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called right after a negedge with the DUT idle; returns after the negedge
  // that follows the done pulse (DUT back in IDLE). inject_at >= 0 pulses a
  // stray start that many cycles into the run.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input int inject_at, output int done_at);
    logic [W+1:0] e;
    int lat;
    exp_q.push_back(model(ta, tb, ts));
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == inject_at) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    done_at = cyc;
    check("latency", 32'(lat), 32'(W));
    e = exp_q.pop_front();
    check("result", 32'(result), 32'(e[W-1:0]));
    check("carryout", 32'(carryout), 32'(e[W]));
    check("overflow", 32'(overflow), 32'(e[W+1]));
    check("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_falls", 32'(done), 32'd0);
    check("result_holds", 32'(result), 32'(e[W-1:0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, p0;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({carryout, overflow}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h05, 8'h03, 1'b0, -1, t0);
    run_op(8'h7F, 8'h01, 1'b0, -1, t0);
    run_op(8'hFF, 8'h01, 1'b0, -1, t0);
    run_op(8'h03, 8'h05, 1'b1, -1, t0);
    run_op(8'h80, 8'h01, 1'b1, -1, t0);

    // Stray start three cycles into a run must be dropped.
    p0 = done_pulses;
    run_op(8'h10, 8'h20, 1'b0, 3, t0);
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_pulses - p0), 32'd1);
    check("idle_after_stray", 32'(busy), 32'd0);

    // Reset four cycles into a run aborts it silently.
    p0 = done_pulses;
    start = 1'b1; a = 8'h37; b = 8'h11; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'({carryout, overflow}), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_pulses - p0), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, -1, t0);

    // Back-to-back: each run_op returns on the first idle cycle.
    run_op(8'h12, 8'h34, 1'b0, -1, t0);
    run_op(8'h40, 8'h41, 1'b1, -1, t1);
    check("b2b_gap", 32'(t1 - t0), 32'(W + 2));

    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), -1, t0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
